// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq: byte-by-byte push/pull sequencer for the KCPU stack instructions.
// Optional macro JTKCPU_STACK_WAIT_EN adds i_mem_rdy, which stalls the WR and RD states.

module jtkcpu_stack_seq_chk (
   input  logic clk,
   input  logic rst_n,
   input  logic i_dec,
   input  logic i_inc,
   input  logic i_we,
   input  logic i_rd,
   input  logic i_busy
);
   // strobes are mutually exclusive
   a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({i_dec, i_inc, i_we, i_rd}));

   // no strobe is ever seen outside a busy sequence
   a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      !i_busy |-> ({i_dec, i_inc, i_we, i_rd} == 4'b0000));
endmodule

module jtkcpu_stack_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_cen,
   input  logic       i_start_psh,
   input  logic       i_start_pul,
   input  logic [7:0] i_postbyte,
   input  logic       i_ussel,
`ifdef JTKCPU_STACK_WAIT_EN
   input  logic       i_mem_rdy,
`endif
   output logic [7:0] o_psh_sel,
   output logic       o_psh_hihalf,
   output logic       o_psh_ussel,
   output logic       o_pul_en,
   output logic       o_psh_dec,
   output logic       o_psh_inc,
   output logic       o_stack_busy,
   output logic       o_mem_we,
   output logic       o_mem_rd,
   output logic       o_done
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DEC  = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_INC  = 3'd4
   } state_t;

   state_t     r_state;
   logic [7:0] r_sel;
   logic       r_hihalf;
   logic       r_ussel;
   logic       r_pul;
   logic       r_dec;
   logic       r_inc;
   logic       r_busy;
   logic       r_we;
   logic       r_rd;
   logic       r_done;

   state_t     w_nxt_state;
   logic [7:0] w_nxt_sel;
   logic       w_nxt_hihalf;
   logic       w_nxt_ussel;
   logic       w_nxt_pul;
   logic       w_nxt_done;
   logic [2:0] w_cur_idx;
   logic [7:0] w_clr_sel;
   logic       w_rdy;

   // index of the highest set bit: next register to push
   function automatic logic [2:0] f_hi_idx(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // index of the lowest set bit: next register to pull
   function automatic logic [2:0] f_lo_idx(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // mask bits 7..4 are the 16-bit registers
   function automatic logic f_is16(input logic [2:0] idx);
      return idx[2];
   endfunction

`ifdef JTKCPU_STACK_WAIT_EN
   assign w_rdy = i_mem_rdy;
`else
   assign w_rdy = 1'b1;
`endif

   assign w_cur_idx = r_pul ? f_lo_idx(r_sel) : f_hi_idx(r_sel);
   assign w_clr_sel = r_sel & ~(8'd1 << w_cur_idx);

   // next-state and next-register decode
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_sel    = r_sel;
      w_nxt_hihalf = r_hihalf;
      w_nxt_ussel  = r_ussel;
      w_nxt_pul    = r_pul;
      w_nxt_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start_psh || i_start_pul) begin
               w_nxt_sel   = i_postbyte;
               w_nxt_ussel = i_ussel;
               w_nxt_pul   = ~i_start_psh;
               // a pull of a 16-bit register starts with its high byte
               w_nxt_hihalf = i_start_psh ? 1'b0 : f_is16(f_lo_idx(i_postbyte));
               if (i_postbyte == 8'd0) begin
                  w_nxt_hihalf = 1'b0;
                  w_nxt_done   = 1'b1;
               end else if (i_start_psh) begin
                  w_nxt_state = ST_DEC;
               end else begin
                  w_nxt_state = ST_RD;
               end
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_DEC: begin
            w_nxt_state = ST_WR;
         end
         ST_WR: begin
            if (!w_rdy) begin
               w_nxt_state = ST_WR;
            end else if (f_is16(w_cur_idx) && !r_hihalf) begin
               w_nxt_hihalf = 1'b1;
               w_nxt_state  = ST_DEC;
            end else begin
               w_nxt_sel    = w_clr_sel;
               w_nxt_hihalf = 1'b0;
               if (w_clr_sel == 8'd0) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_done  = 1'b1;
               end else begin
                  w_nxt_state = ST_DEC;
               end
            end
         end
         ST_RD: begin
            if (w_rdy) begin
               w_nxt_state = ST_INC;
            end else begin
               w_nxt_state = ST_RD;
            end
         end
         ST_INC: begin
            if (f_is16(w_cur_idx) && r_hihalf) begin
               w_nxt_hihalf = 1'b0;
               w_nxt_state  = ST_RD;
            end else begin
               w_nxt_sel = w_clr_sel;
               if (w_clr_sel == 8'd0) begin
                  w_nxt_hihalf = 1'b0;
                  w_nxt_state  = ST_IDLE;
                  w_nxt_done   = 1'b1;
               end else begin
                  w_nxt_hihalf = f_is16(f_lo_idx(w_clr_sel));
                  w_nxt_state  = ST_RD;
               end
            end
         end
         default: begin
            w_nxt_state  = ST_IDLE;
            w_nxt_sel    = 8'd0;
            w_nxt_hihalf = 1'b0;
         end
      endcase
   end

   // state and registered outputs; strobes decode the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= 8'd0;
         r_hihalf <= 1'b0;
         r_ussel  <= 1'b0;
         r_pul    <= 1'b0;
         r_dec    <= 1'b0;
         r_inc    <= 1'b0;
         r_busy   <= 1'b0;
         r_we     <= 1'b0;
         r_rd     <= 1'b0;
         r_done   <= 1'b0;
      end else if (i_cen) begin
         r_state  <= w_nxt_state;
         r_sel    <= w_nxt_sel;
         r_hihalf <= w_nxt_hihalf;
         r_ussel  <= w_nxt_ussel;
         r_pul    <= w_nxt_pul;
         r_dec    <= (w_nxt_state == ST_DEC);
         r_inc    <= (w_nxt_state == ST_INC);
         r_busy   <= (w_nxt_state != ST_IDLE);
         r_we     <= (w_nxt_state == ST_WR);
         r_rd     <= (w_nxt_state == ST_RD);
         r_done   <= w_nxt_done;
      end
   end

   assign o_psh_sel    = r_sel;
   assign o_psh_hihalf = r_hihalf;
   assign o_psh_ussel  = r_ussel;
   assign o_pul_en     = r_pul;
   assign o_psh_dec    = r_dec;
   assign o_psh_inc    = r_inc;
   assign o_stack_busy = r_busy;
   assign o_mem_we     = r_we;
   assign o_mem_rd     = r_rd;
   assign o_done       = r_done;

   jtkcpu_stack_seq_chk u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_dec  (r_dec),
      .i_inc  (r_inc),
      .i_we   (r_we),
      .i_rd   (r_rd),
      .i_busy (r_busy)
   );

endmodule

// File: doc/jtkcpu_stack_seq.md
# jtkcpu_stack_seq

Push/pull sequencer for the KCPU stack instructions (PSHS/PSHU/PULS/PULU and interrupt entry/return). It converts a register-mask postbyte into a byte-by-byte sequence of stack-pointer decrement/increment, memory write/read strobes and register-select signals. It sits directly upstream of the register file and drives its `psh_sel`, `psh_hihalf`, `psh_ussel`, `pul_en`, `psh_dec` and `stack_busy` inputs. The register file returns `psh_mux`, the push data byte, and `psh_addr`, the stack address, to the memory interface.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active low.
- `cen` in 1: clock enable. All state advances only on `clk` edges with `cen`=1.
- `start_psh` in 1: request a push sequence. Sampled in IDLE.
- `start_pul` in 1: request a pull sequence. Sampled in IDLE.
- `postbyte` in 8: register mask. Bit 7=PC, 6=U/S (other stack), 5=Y, 4=X, 3=DP, 2=B, 1=A, 0=CC.
- `ussel` in 1: selects the stack pointer. 1 = U stack, 0 = S stack.
- `psh_sel` out 8: mask of registers still pending in this sequence.
- `psh_hihalf` out 1: current byte is the high half of a 16-bit register.
- `psh_ussel` out 1: latched copy of `ussel` for the whole sequence.
- `pul_en` out 1: the sequence is a pull.
- `psh_dec` out 1: decrement the selected stack pointer this cycle.
- `psh_inc` out 1: increment the selected stack pointer this cycle.
- `stack_busy` out 1: sequence in progress.
- `mem_we` out 1: write `psh_mux` to `psh_addr` this cycle.
- `mem_rd` out 1: read from `psh_addr` this cycle; data is valid on `mdata` at the end of the cycle.
- `done` out 1: one-cen-cycle pulse that marks the end of the sequence.

## Operation
- States: IDLE, DEC, WR, RD, INC. All outputs are registered.
- IDLE:
  - On `cen` with `start_psh`: latch the mask ← `postbyte`, `psh_ussel` ← `ussel`, `pul_en` ← 0, go to DEC.
  - On `cen` with `start_pul` (and no `start_psh`): latch the same way, `pul_en` ← 1, go to RD.
  - If both starts are asserted, the push wins.
  - If the latched mask is 0, no memory access occurs. The sequencer stays in IDLE and pulses `done` in the next cen cycle.
  - Starts are ignored while `stack_busy`=1.
- Push order: highest set bit first (PC, U/S, Y, X, DP, B, A, CC).
  - 16-bit registers push the low byte first (`psh_hihalf`=0), then the high byte (`psh_hihalf`=1).
- Pull order: lowest set bit first (CC … PC).
  - 16-bit registers pull the high byte first (`psh_hihalf`=1), then the low byte.
- Push, per byte:
  - DEC: `psh_dec`=1.
  - WR: `mem_we`=1.
  - Leaving WR after the last byte of a register clears that register's bit in the mask.
- Pull, per byte:
  - RD: `mem_rd`=1.
  - INC: `psh_inc`=1.
  - Leaving INC after the last byte clears the register's bit.
- After the final WR or INC, when the mask becomes 0: go to IDLE, `stack_busy` ← 0, `done` ← 1 for exactly one cen cycle.
- The byte count per register is 2 for bits 7..4 and 1 for bits 3..0. Register width comes only from the bit position.
- `psh_dec`, `psh_inc`, `mem_we` and `mem_rd` are mutually exclusive. They are never asserted in IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `psh_sel`=0, `psh_hihalf`=0, `psh_ussel`=0, `pul_en`=0
  - `psh_dec`=0, `psh_inc`=0, `stack_busy`=0
  - `mem_we`=0, `mem_rd`=0, `done`=0
- Asserting `rst_n` low mid-sequence aborts immediately to IDLE with the values above. No `done` is generated.
- Start-to-first-strobe latency: 1 cen cycle. `stack_busy` and the first `psh_dec` or `mem_rd` appear in the cen cycle after the start.
- An N-byte sequence holds `stack_busy` for 2N cen cycles. `done` is asserted in cen cycle 2N+1.
- When `cen`=0, all outputs hold their values.

## Configuration
- `JTKCPU_STACK_WAIT_EN`:
  - Defined: adds input `mem_rdy` (1 bit). WR and RD are held, with their strobes kept asserted, until a `cen` cycle with `mem_rdy`=1. DEC and INC are never stalled.
  - Undefined: the port is absent and the design behaves as if `mem_rdy`=1.

## Test plan
- Push S, `postbyte`=0x06 (A, B) → DEC/WR B, then DEC/WR A. Check `psh_sel` 0x06→0x02→0x00, `done` at cen cycle 5, `psh_ussel`=0.
- Push U, `postbyte`=0xFF → 12 bytes, with PC low then high first and CC last. `stack_busy` held for 24 cycles. `psh_hihalf` sequence is 0,1 for each of the four 16-bit registers.
- Pull S, `postbyte`=0x81 (CC, PC) → RD/INC CC, then PC high, then PC low. `pul_en`=1 throughout, `done` at cycle 7, no `mem_we`.
- `postbyte`=0x00 with `start_pul` → no strobes, `done` one cycle later. Also: `start_psh` and `start_pul` together with 0x02 → a push of A runs.
- Push 0xF0 with `rst_n` pulsed low at the 5th cycle → all outputs 0 immediately, no `done`, a new start is accepted afterwards. Also: with `cen` toggling 1-of-3, the same sequences produce identical results per cen.
- With `JTKCPU_STACK_WAIT_EN` defined, push 0x01 with `mem_rdy` low for 3 cen cycles → `mem_we` held 4 cycles, a single `psh_dec`, `done` at cycle 6.
